// File: rtl/i2c_seq_pkg.sv
// i2c_seq_pkg
//   Shared definitions for the I2C init sequencer: table entry opcodes, the
//   sequencer state encoding and helpers that derive the entry, register
//   address and data widths from the i2c_master byte counts.
package i2c_seq_pkg;

  // Opcode field, the two MSBs of every table entry. 2'b11 is reserved and is
  // decoded the same way as OP_END.
  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_DELAY = 2'b01;
  localparam logic [1:0] OP_END   = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_HOLD,
    ST_ISSUE,
    ST_WAIT_DONE,
    ST_DELAY,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  // Entry = {op[1:0], reg_addr, data}
  function automatic int entry_width(input int nab, input int ndb);
    return 2 + 8 * nab + 8 * ndb;
  endfunction

  function automatic int raw_width(input int nab);
    return (nab < 1) ? 1 : 8 * nab;
  endfunction

  function automatic int dw_width(input int ndb);
    return 8 * ndb;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/i2c_seq_delay_timer.sv
// i2c_seq_delay_timer
//   Loadable down-counter shared by the DELAY entries and the WAIT_DONE
//   timeout. Counting stops at zero.
// Ports
//   ifclk     in  clock
//   resetb    in  asynchronous active-low reset
//   load      in  load load_val (has priority over count)
//   load_val  in  CW-bit value to load
//   count     in  decrement by one when nonzero
//   zero      out counter currently holds zero
module i2c_seq_delay_timer #(
  parameter int CW = 16
) (
  input  logic          ifclk,
  input  logic          resetb,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          count,
  output logic          zero
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (count && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/i2c_init_sequencer.sv
// i2c_init_sequencer
//   Owns the i2c_master control port while a script of register writes and
//   delays (read from an external table) runs, retrying NACKed writes, and
//   hands the port back to the DI glue when the script ends or aborts.
//   NUM_ADDR_BYTES is expected to be at least 1.
// Ports
//   ifclk, resetb               clock, asynchronous active-low reset
//   start                       pulse: run script from entry 0 (ignored while running)
//   tbl_addr / tbl_data         table read port, one-cycle read latency
//   di_*                        DI glue requests toward the master
//   m_*  (out)                  controls to i2c_master
//   m_busy, m_done, m_status    i2c_master status; nonzero m_status = NACK
//   seq_active                  script running (DI must be held off)
//   seq_done / seq_error        sticky outcome of the last script
//   err_index / err_status      failing entry and its status (16'hFFFF = timeout)
module i2c_init_sequencer
  import i2c_seq_pkg::*;
#(
  parameter int NUM_ADDR_BYTES = 2,
  parameter int NUM_DATA_BYTES = 1,
  parameter int TBL_AW         = 8,
  parameter int MAX_RETRIES    = 3,
  parameter int DELAY_SHIFT    = 10,
  parameter int TIMEOUT_CYC    = 65535,
  parameter bit AUTO_START     = 1'b1,
  localparam int EW = entry_width(NUM_ADDR_BYTES, NUM_DATA_BYTES),
  localparam int RAW = raw_width(NUM_ADDR_BYTES),
  localparam int DW = dw_width(NUM_DATA_BYTES),
  localparam int SW = NUM_ADDR_BYTES + NUM_DATA_BYTES + 1
) (
  input  logic              ifclk,
  input  logic              resetb,
  input  logic              start,
  output logic [TBL_AW-1:0] tbl_addr,
  input  logic [EW-1:0]     tbl_data,
  input  logic              di_we,
  input  logic              di_re,
  input  logic              di_write_mode,
  input  logic              di_read_mode,
  input  logic [RAW-1:0]    di_reg_addr,
  input  logic [DW-1:0]     di_datai,
  output logic              m_we,
  output logic              m_re,
  output logic              m_write_mode,
  output logic              m_read_mode,
  output logic [RAW-1:0]    m_reg_addr,
  output logic [DW-1:0]     m_datai,
  input  logic              m_busy,
  input  logic              m_done,
  input  logic [SW-1:0]     m_status,
  output logic              seq_active,
  output logic              seq_done,
  output logic              seq_error,
  output logic [TBL_AW-1:0] err_index,
  output logic [15:0]       err_status
);

  // Timer must hold both the longest DELAY (max data << DELAY_SHIFT) and the timeout.
  localparam int CW = max_int(DW + DELAY_SHIFT, $clog2(TIMEOUT_CYC + 1));
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYC - 1);
  localparam seq_state_t RESET_STATE = AUTO_START ? ST_FETCH : ST_IDLE;

  seq_state_t        state_q, state_d;
  logic [TBL_AW-1:0] idx_q, idx_d;
  logic [3:0]        tries_q, tries_d;
  logic [RAW-1:0]    addr_q, addr_d;
  logic [DW-1:0]     data_q, data_d;
  logic              seq_active_q, seq_active_d;
  logic              seq_done_q, seq_done_d;
  logic              seq_error_q, seq_error_d;
  logic [TBL_AW-1:0] err_index_q, err_index_d;
  logic [15:0]       err_status_q, err_status_d;
  logic              start_pend_q, start_pend_d;

  logic [1:0]        entry_op;
  logic [RAW-1:0]    entry_addr;
  logic [DW-1:0]     entry_data;
  logic              last_entry;
  logic              issue_go;
  logic              tmr_load;
  logic [CW-1:0]     tmr_val;
  logic              tmr_count;
  logic              tmr_zero;

  assign entry_op   = tbl_data[EW-1 -: 2];
  assign entry_addr = tbl_data[DW +: RAW];
  assign entry_data = tbl_data[DW-1:0];
  assign last_entry = &idx_q;
  assign issue_go   = (state_q == ST_ISSUE);

  i2c_seq_delay_timer #(
    .CW(CW)
  ) u_timer (
    .ifclk   (ifclk),
    .resetb  (resetb),
    .load    (tmr_load),
    .load_val(tmr_val),
    .count   (tmr_count),
    .zero    (tmr_zero)
  );

  // Sequencer next-state logic. Finishing the last table slot acts as an
  // implicit END so the index never wraps back into entry 0.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    tries_d      = tries_q;
    addr_d       = addr_q;
    data_d       = data_q;
    seq_done_d   = seq_done_q;
    seq_error_d  = seq_error_q;
    err_index_d  = err_index_q;
    err_status_d = err_status_q;
    start_pend_d = start_pend_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    tmr_count    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          seq_done_d   = 1'b0;
          seq_error_d  = 1'b0;
          err_index_d  = '0;
          err_status_d = '0;
          idx_d        = '0;
          tries_d      = '0;
        end
        // A start seen while a DI transfer is in flight waits for the master to go idle.
        if ((start || start_pend_q) && !m_busy) begin
          start_pend_d = 1'b0;
          state_d      = ST_FETCH;
        end else if (start) begin
          start_pend_d = 1'b1;
        end
      end

      ST_FETCH: begin
        state_d = ST_DECODE;
      end

      ST_DECODE: begin
        tries_d = '0;
        addr_d  = entry_addr;
        data_d  = entry_data;
        case (entry_op)
          OP_WRITE: begin
            state_d = ST_HOLD;
          end
          OP_DELAY: begin
            if (entry_data == '0) begin
              if (last_entry) begin
                state_d    = ST_DONE;
                seq_done_d = 1'b1;
              end else begin
                idx_d   = idx_q + TBL_AW'(1);
                state_d = ST_FETCH;
              end
            end else begin
              // Timer runs to zero from N-1, giving exactly N cycles in ST_DELAY.
              tmr_load = 1'b1;
              tmr_val  = (CW'(entry_data) << DELAY_SHIFT) - CW'(1);
              state_d  = ST_DELAY;
            end
          end
          OP_END: begin
            state_d    = ST_DONE;
            seq_done_d = 1'b1;
          end
          default: begin
            state_d    = ST_DONE;
            seq_done_d = 1'b1;
          end
        endcase
      end

      ST_HOLD: begin
        if (!m_busy) begin
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        tmr_load = 1'b1;
        tmr_val  = TIMEOUT_VAL;
        state_d  = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        tmr_count = 1'b1;
        if (m_done) begin
          if (m_status == '0) begin
            if (last_entry) begin
              state_d    = ST_DONE;
              seq_done_d = 1'b1;
            end else begin
              idx_d   = idx_q + TBL_AW'(1);
              state_d = ST_FETCH;
            end
          end else if (tries_q < 4'(MAX_RETRIES)) begin
            tries_d = tries_q + 4'd1;
            state_d = ST_HOLD;
          end else begin
            state_d      = ST_ERROR;
            seq_error_d  = 1'b1;
            err_index_d  = idx_q;
            err_status_d = 16'(m_status);
          end
        end else if (tmr_zero) begin
          state_d      = ST_ERROR;
          seq_error_d  = 1'b1;
          err_index_d  = idx_q;
          err_status_d = 16'hFFFF;
        end
      end

      ST_DELAY: begin
        tmr_count = 1'b1;
        if (tmr_zero) begin
          if (last_entry) begin
            state_d    = ST_DONE;
            seq_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + TBL_AW'(1);
            state_d = ST_FETCH;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Registered so it is low in reset even when AUTO_START resets into ST_FETCH.
    seq_active_d = state_d inside {ST_FETCH, ST_DECODE, ST_HOLD, ST_ISSUE,
                                   ST_WAIT_DONE, ST_DELAY};
  end

  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_q      <= RESET_STATE;
      idx_q        <= '0;
      tries_q      <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      seq_active_q <= 1'b0;
      seq_done_q   <= 1'b0;
      seq_error_q  <= 1'b0;
      err_index_q  <= '0;
      err_status_q <= '0;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tries_q      <= tries_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      seq_active_q <= seq_active_d;
      seq_done_q   <= seq_done_d;
      seq_error_q  <= seq_error_d;
      err_index_q  <= err_index_d;
      err_status_q <= err_status_d;
      start_pend_q <= start_pend_d;
    end
  end

  // Master port mux: DI passes straight through when no script owns the master.
  always_comb begin
    if (seq_active_q) begin
      m_we         = issue_go;
      m_write_mode = issue_go;
      m_re         = 1'b0;
      m_read_mode  = 1'b0;
      m_reg_addr   = addr_q;
      m_datai      = data_q;
    end else begin
      m_we         = di_we;
      m_write_mode = di_write_mode;
      m_re         = di_re;
      m_read_mode  = di_read_mode;
      m_reg_addr   = di_reg_addr;
      m_datai      = di_datai;
    end
  end

  assign tbl_addr   = idx_q;
  assign seq_active = seq_active_q;
  assign seq_done   = seq_done_q;
  assign seq_error  = seq_error_q;
  assign err_index  = err_index_q;
  assign err_status = err_status_q;

endmodule
